plb_state_mem: RTL

State-vector memory that responds to the PLB port driven by the EKF-SLAM state-vector/mapping datapath. It stores robot pose at addresses 1..3 (x, y, θ) and landmark k at addresses 2k+2 and 2k+3. It serves single-cycle-issue reads and writes from that initiator and zero-fills itself after reset or on request. It also offers a host dump port that streams a prefix of the vector out with a valid/ready handshake, yielding to PLB traffic.

---
 rtl/plb_state_mem.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/plb_state_mem.sv
`default_nettype none
// ============================================================================
//  Module   : plb_state_mem
//  Brief    : EKF-SLAM state-vector memory with a PLB access port, self-clear
//             engine and a valid/ready host dump stream that yields to PLB.
//  Revision : 1.0  initial release
// ============================================================================
module plb_state_mem #(
   parameter int RSA_DW = 32,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   input  logic              PLB_en,
   input  logic              PLB_we,
   input  logic [31:0]       PLB_addr,
   input  logic [RSA_DW-1:0] PLB_din,
   output logic [RSA_DW-1:0] PLB_dout,
   output logic              addr_err,
   input  logic              init_start,
   output logic              init_busy,
   output logic              init_done,
   input  logic              dump_start,
   input  logic [AW:0]       dump_len,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [RSA_DW-1:0] dump_data,
   output logic [AW-1:0]     dump_addr,
   output logic              dump_done
);

   localparam int          c_DEPTH     = 2 ** AW;
   localparam logic [AW:0] c_DEPTH_LEN = {1'b1, {AW{1'b0}}};
   localparam logic [AW-1:0] c_LAST    = {AW{1'b1}};

   typedef enum logic [1:0] {
      S_CLEAR    = 2'd0,
      S_IDLE     = 2'd1,
      S_DUMP_RD  = 2'd2,
      S_DUMP_OUT = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [RSA_DW-1:0] r_mem [c_DEPTH];

   logic [AW-1:0]     r_cnt;
   logic [AW:0]       r_ptr;
   logic [AW:0]       r_len;

   logic              w_clr_last;
   logic              w_init_go;
   logic              w_dump_go;
   logic              w_dump_zero;
   logic              w_dump_load;
   logic              w_dump_hs;
   logic              w_dump_last;
   logic [AW:0]       w_ptr_inc;
   logic [AW:0]       w_len_clamp;

   logic              w_plb_ok;
   logic              w_addr_oor;
   logic              w_plb_wr;
   logic              w_mem_we;
   logic [AW-1:0]     w_mem_wa;
   logic [RSA_DW-1:0] w_mem_wd;
   logic [AW-1:0]     w_rd_addr;
   logic [RSA_DW-1:0] w_rd_data;

   assign w_ptr_inc   = r_ptr + (AW+1)'(1);
   assign w_len_clamp = (dump_len > c_DEPTH_LEN) ? c_DEPTH_LEN : dump_len;

   // PLB is blocked only while the clear engine owns the write port
   assign w_plb_ok   = PLB_en && (r_state != S_CLEAR);
   assign w_addr_oor = |PLB_addr[31:AW];
   assign w_plb_wr   = w_plb_ok && PLB_we && !w_addr_oor;

   // Dump reads only happen on cycles without PLB traffic, so one read port suffices
   assign w_rd_addr = PLB_en ? PLB_addr[AW-1:0] : r_ptr[AW-1:0];
   assign w_rd_data = r_mem[w_rd_addr];

   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_clr_last   = 1'b0;
      w_init_go    = 1'b0;
      w_dump_go    = 1'b0;
      w_dump_zero  = 1'b0;
      w_dump_load  = 1'b0;
      w_dump_hs    = 1'b0;
      w_dump_last  = 1'b0;
      case (r_state)
         S_CLEAR: begin
            if (r_cnt == c_LAST) begin
               w_clr_last   = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_IDLE: begin
            if (init_start) begin
               w_init_go    = 1'b1;
               w_state_next = S_CLEAR;
            end else if (dump_start) begin
               w_dump_go = 1'b1;
               if (dump_len == '0) begin
                  w_dump_zero = 1'b1;
               end else begin
                  w_state_next = S_DUMP_RD;
               end
            end
         end
         S_DUMP_RD: begin
            if (!PLB_en) begin
               w_dump_load  = 1'b1;
               w_state_next = S_DUMP_OUT;
            end
         end
         S_DUMP_OUT: begin
            if (dump_ready) begin
               w_dump_hs = 1'b1;
               if (w_ptr_inc == r_len) begin
                  w_dump_last  = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_state_next = S_DUMP_RD;
               end
            end
         end
         default: w_state_next = S_CLEAR;
      endcase
   end

   always_comb begin
      w_mem_we = 1'b0;
      w_mem_wa = r_cnt;
      w_mem_wd = '0;
      if (r_state == S_CLEAR) begin
         w_mem_we = 1'b1;
      end else if (w_plb_wr) begin
         w_mem_we = 1'b1;
         w_mem_wa = PLB_addr[AW-1:0];
         w_mem_wd = PLB_din;
      end
   end

   // Storage is not reset; the clear engine zero-fills it after every reset
   always_ff @(posedge clk) begin
      if (sys_rst_n && w_mem_we) begin
         r_mem[w_mem_wa] <= w_mem_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_len      <= '0;
         PLB_dout   <= '0;
         addr_err   <= 1'b0;
         init_busy  <= 1'b1;
         init_done  <= 1'b0;
         dump_valid <= 1'b0;
         dump_data  <= '0;
         dump_addr  <= '0;
         dump_done  <= 1'b0;
      end else begin
         init_done <= w_clr_last;
         dump_done <= w_dump_zero | w_dump_last;

         if (w_init_go) begin
            r_cnt     <= '0;
            init_busy <= 1'b1;
         end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + AW'(1);
            if (w_clr_last) begin
               init_busy <= 1'b0;
            end
         end

         if (w_dump_go) begin
            r_len <= w_len_clamp;
            r_ptr <= '0;
         end else if (w_dump_hs) begin
            r_ptr <= w_ptr_inc;
         end

         // The beat is captured once, so later PLB writes cannot disturb it
         if (w_dump_load) begin
            dump_valid <= 1'b1;
            dump_data  <= w_rd_data;
            dump_addr  <= r_ptr[AW-1:0];
         end else if (w_dump_hs) begin
            dump_valid <= 1'b0;
         end

         if (w_plb_ok) begin
            if (w_addr_oor) begin
               PLB_dout <= '0;
               addr_err <= 1'b1;
            end else if (PLB_we) begin
               PLB_dout <= PLB_din;
            end else begin
               PLB_dout <= w_rd_data;
            end
         end
      end
   end

endmodule
`default_nettype wire
